// File: rtl/result_digit_streamer.sv
// Streams a captured binary result as BCD digits, most significant first, over valid/ready.
// Conversion is iterative double dabble, one bit per cycle; leading zeros are skipped.
module result_digit_streamer #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             negative,
  output logic [3:0]       digit,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             digit_last
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, STREAM} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic                neg_q, neg_d;
  logic [BW+WIDTH-1:0] shifted;
  logic                busy_q, digit_valid_q, digit_last_q;
  logic [3:0]          digit_q;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] nib(input logic [BW-1:0] b, input logic [PW-1:0] p);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (p == PW'(i)) r = b[4*i +: 4];
    end
    return r;
  endfunction

  // Index of the highest nonzero nibble; 0 for an all-zero value so "0" is still emitted.
  function automatic logic [PW-1:0] msd(input logic [BW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) r = PW'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    shifted = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d   = SIGNED && value[WIDTH-1];
          mag_d   = neg_d ? (~value + 1'b1) : value;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        shifted = {add3(bcd_q), mag_q} << 1;
        bcd_d   = shifted[BW+WIDTH-1:WIDTH];
        mag_d   = shifted[WIDTH-1:0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          ptr_d   = msd(bcd_d);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (digit_ready) begin
          if (ptr_q == '0) state_d = IDLE;
          else             ptr_d   = ptr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so nothing combinational reaches a port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      neg_q         <= 1'b0;
      busy_q        <= 1'b0;
      digit_valid_q <= 1'b0;
      digit_last_q  <= 1'b0;
      digit_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      neg_q         <= neg_d;
      busy_q        <= (state_d != IDLE);
      digit_valid_q <= (state_d == STREAM);
      digit_last_q  <= (state_d == STREAM) && (ptr_d == '0);
      digit_q       <= (state_d == STREAM) ? nib(bcd_d, ptr_d) : 4'd0;
    end
  end

  always_ff @(posedge clock) begin
    bcd_q <= bcd_d;
    mag_q <= mag_d;
  end

  assign busy        = busy_q;
  assign negative    = neg_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign digit_last  = digit_last_q;

endmodule

// File: tb/tb_result_digit_streamer.sv
// Directed bench for result_digit_streamer: signed instance plus an unsigned instance.
module tb_result_digit_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, start_u;
  logic [15:0] value, value_u;
  logic        busy, busy_u;
  logic        negative, negative_u;
  logic [3:0]  digit, digit_u;
  logic        digit_valid, digit_valid_u;
  logic        digit_ready, digit_ready_u;
  logic        digit_last, digit_last_u;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  result_digit_streamer #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .busy(busy), .negative(negative), .digit(digit),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .digit_last(digit_last)
  );

  result_digit_streamer #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) dut_u (
    .clock(clock), .reset(reset), .start(start_u), .value(value_u),
    .busy(busy_u), .negative(negative_u), .digit(digit_u),
    .digit_valid(digit_valid_u), .digit_ready(digit_ready_u), .digit_last(digit_last_u)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then verify busy/negative at n+1 and that no digit appears before n+17.
  task automatic do_start(input string tag, input logic [15:0] v, input logic exp_neg);
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    value = 16'hA5A5;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    chk({tag, "_neg"}, 32'(negative), 32'(exp_neg));
    chk({tag, "_nv_early"}, 32'(digit_valid), 32'd0);
    repeat (15) tick();
    chk({tag, "_nv_n16"}, 32'(digit_valid), 32'd0);
    tick();
  endtask

  // Expects exp_q digits on consecutive cycles with digit_ready held high.
  task automatic stream_check(input string tag, input logic exp_neg);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(digit_valid), 32'd1);
      chk({tag, "_digit"}, 32'(digit), 32'(exp_q[i]));
      chk({tag, "_last"}, 32'(digit_last), 32'(i == n - 1));
      chk({tag, "_negs"}, 32'(negative), 32'(exp_neg));
      tick();
    end
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_valid_fall"}, 32'(digit_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; value = '0; digit_ready = 1'b1;
    start_u = 1'b0; value_u = '0; digit_ready_u = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_neg", 32'(negative), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_valid", 32'(digit_valid), 32'd0);
    chk("rst_last", 32'(digit_last), 32'd0);
    reset = 1'b0;
    tick();

    do_start("zero", 16'd0, 1'b0);
    exp_q = '{0};
    stream_check("zero", 1'b0);

    do_start("d1234", 16'd1234, 1'b0);
    exp_q = '{1, 2, 3, 4};
    stream_check("d1234", 1'b0);

    do_start("m1", 16'hFFFF, 1'b1);
    exp_q = '{1};
    stream_check("m1", 1'b1);

    // Started in the same cycle busy falls, so back-to-back acceptance is exercised too.
    do_start("m32768", 16'h8000, 1'b1);
    exp_q = '{3, 2, 7, 6, 8};
    stream_check("m32768", 1'b1);

    do_start("stall", 16'd1234, 1'b0);
    chk("stall_d1", 32'(digit), 32'd1);
    tick();
    digit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      value = 16'd9;
      chk("stall_hold_digit", 32'(digit), 32'd2);
      chk("stall_hold_valid", 32'(digit_valid), 32'd1);
      chk("stall_hold_last", 32'(digit_last), 32'd0);
      tick();
    end
    start = 1'b0;
    digit_ready = 1'b1;
    chk("stall_still2", 32'(digit), 32'd2);
    tick();
    chk("stall_d3", 32'(digit), 32'd3);
    tick();
    chk("stall_d4", 32'(digit), 32'd4);
    chk("stall_d4_last", 32'(digit_last), 32'd1);
    start = 1'b1;
    value = 16'd9;
    tick();
    start = 1'b0;
    chk("stall_done_busy", 32'(busy), 32'd0);
    chk("stall_done_valid", 32'(digit_valid), 32'd0);
    tick();
    chk("ignore_busy", 32'(busy), 32'd0);
    chk("ignore_neg", 32'(negative), 32'd0);
    repeat (18) tick();
    chk("ignore_novalid", 32'(digit_valid), 32'd0);

    do_start("m1b", 16'hFFFF, 1'b1);
    chk("m1b_valid", 32'(digit_valid), 32'd1);
    tick();
    do_start("rst", 16'd1234, 1'b0);
    chk("rst_pre_d1", 32'(digit), 32'd1);
    tick();
    chk("rst_pre_d2", 32'(digit), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_valid", 32'(digit_valid), 32'd0);
    chk("rstm_digit", 32'(digit), 32'd0);
    chk("rstm_neg", 32'(negative), 32'd0);
    chk("rstm_last", 32'(digit_last), 32'd0);
    tick();
    chk("rstm_idle", 32'(busy), 32'd0);

    do_start("d7", 16'd7, 1'b0);
    exp_q = '{7};
    stream_check("d7", 1'b0);

    start_u = 1'b1;
    value_u = 16'hFFFF;
    tick();
    start_u = 1'b0;
    chk("u_busy", 32'(busy_u), 32'd1);
    chk("u_neg", 32'(negative_u), 32'd0);
    repeat (16) tick();
    exp_q = '{6, 5, 5, 3, 5};
    for (int i = 0; i < 5; i++) begin
      chk("u_valid", 32'(digit_valid_u), 32'd1);
      chk("u_digit", 32'(digit_u), 32'(exp_q[i]));
      chk("u_last", 32'(digit_last_u), 32'(i == 4));
      chk("u_negs", 32'(negative_u), 32'd0);
      tick();
    end
    chk("u_busy_fall", 32'(busy_u), 32'd0);
    chk("u_valid_fall", 32'(digit_valid_u), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
